conv2d_stream_engine: RTL
=========================

// Module: conv2d_stream_engine
// PURPOSE
//  Parametrised 2-D convolution core behind the cnnip AXI4-Lite register shell.
//  Holds one image (up to IMG_MAX x IMG_MAX) and one kernel (up to K_MAX x K_MAX),
//  both loaded through a write port. Runtime image size, kernel size, stride and ReLU.
//  Streams results over a valid/ready port with backpressure; one MAC per cycle.
// PARAMETERS
//  DATA_W   16  signed width of image pixels and kernel weights
//  IMG_MAX  8   max image dimension N; image buffer has IMG_MAX*IMG_MAX words
//  K_MAX    5   max kernel dimension K; kernel buffer has K_MAX*K_MAX words
//  derived: AW=clog2(IMG_MAX*IMG_MAX), DW=clog2(IMG_MAX+1), ACC_W=2*DATA_W+clog2(K_MAX*K_MAX)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  mem_we     in   1       buffer write strobe; ignored while busy=1
//  mem_sel    in   1       0=image buffer, 1=kernel buffer
//  mem_addr   in   AW      word index, row-major (row*dim+col); kernel uses low bits
//  mem_wdata  in   DATA_W  signed pixel/weight
//  cfg_n      in   DW      image dimension N, sampled on start
//  cfg_k      in   DW      kernel dimension K, sampled on start
//  cfg_stride in   2       stride S (1..3), sampled on start
//  cfg_relu   in   1       1=clamp negative results to 0, sampled on start
//  start      in   1       1-cycle request; ignored while busy=1
//  busy       out  1       high from cycle after accepted start until IDLE re-entered
//  done       out  1       1-cycle pulse at end of job (normal or error)
//  err        out  1       1-cycle pulse with done when config illegal
//  out_valid  out  1       result available
//  out_ready  in   1       consumer accepts when out_valid&out_ready
//  out_data   out  ACC_W   signed convolution result (post-ReLU if enabled)
//  out_last   out  1       high with out_valid on final result of the job
// BEHAVIOUR
//  Reset: busy,done,err,out_valid,out_last=0; out_data=0; FSM->IDLE. Buffers NOT cleared.
//  FSM: IDLE -start-> CHECK -> (illegal ? FIN : MAC) ; MAC -K*K taps-> EMIT ;
//       EMIT -handshake-> (last ? FIN : MAC) ; FIN -> IDLE (done=1 in FIN).
//  Illegal config: K==0, N==0, S==0, K>K_MAX, N>IMG_MAX, K>N -> err=1,done=1, no output.
//  Outputs per job: M*M, M=floor((N-K)/S)+1, raster order, window origin (r*S,c*S).
//  MAC: accumulator cleared on MAC entry; tap order kr outer, kc inner; buffers read
//   combinationally; product DATA_W x DATA_W signed -> 2*DATA_W, sign-extended to ACC_W.
//  Latency: start at edge t -> CHECK t+1 -> MAC t+2..t+1+K*K -> out_valid from t+2+K*K.
//   Each later output: K*K MAC cycles after previous handshake, then out_valid.
//  Handshake: out_valid,out_data,out_last held stable until out_ready; no drop, no dup.
//   out_ready may be high before out_valid; transfer only when both high.
//  ReLU: applied once at EMIT entry; result<0 -> 0 when cfg_relu=1.
//  start while busy, mem_we while busy: ignored, no side effect.
//  start and mem_we in same IDLE cycle: write completes; job sees the new word.
//  rst mid-job: abort immediately, no done/err; next start behaves as fresh job.
// STRUCTURE
//  conv_pkg: FSM state enum, clog2 helper, ACC_W/AW/DW derivation, ILLEGAL checks.
//  Sub-module conv_window_addr: window (r,c) and tap (kr,kc) counters with stride,
//   produces img/kernel addresses plus tap_last and win_last flags.
//  Top: buffers, config latch, FSM, accumulator, output register.
// TESTING (image=1..25 row-major, N=5, K=3 unless stated)
//  1 kernel all 1, S=1, relu=0, out_ready=1 -> 63,72,81,108,117,126,153,162,171; last on 171.
//  2 same, S=2 -> 63,81,153,171; out_last only on 171; done 1 cycle after last handshake.
//  3 kernel all -1, S=2: relu=0 -> -63,-81,-153,-171; relu=1 -> 0,0,0,0.
//  4 case 1 with out_ready low 5 cycles per result -> data/last stable, same 9 values, none lost.
//  5 N=3,K=4 start -> err=1,done=1 at t+2; out_valid never high; busy low after.
//  6 rst during 4th MAC cycle of case 1, restart -> full correct sequence 63..171 again.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the streaming 2-D convolution engine.
package conv_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    function automatic int conv_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A job with any of these settings finishes with an error and no output.
    function automatic logic cfg_illegal(input int n, input int k, input int s,
                                         input int n_max, input int k_max);
        return (k == 0) || (n == 0) || (s == 0) ||
               (k > k_max) || (n > n_max) || (k > n);
    endfunction

endpackage

// File: rtl/conv_window_addr.sv
// Window-origin and tap counters; turns (row, col, kr, kc) into buffer addresses.
module conv_window_addr
    import conv_pkg::*;
#(
    parameter int IMG_MAX = 8,
    parameter int K_MAX   = 5,
    parameter int AW      = 6,
    parameter int DW      = 4,
    parameter int KAW     = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  cfg_n,
    input  logic [DW-1:0]  cfg_k,
    input  logic [1:0]     cfg_s,
    input  logic           win_init,
    input  logic           tap_step,
    input  logic           win_step,
    output logic [AW-1:0]  img_addr,
    output logic [KAW-1:0] kern_addr,
    output logic           tap_last,
    output logic           win_last
);
    // Two spare bits so origin + stride + kernel never wraps.
    localparam int EW = DW + 2;

    logic [EW-1:0] row;
    logic [EW-1:0] col;
    logic [DW-1:0] kr;
    logic [DW-1:0] kc;
    logic [EW-1:0] n_e;
    logic [EW-1:0] k_e;
    logic [EW-1:0] s_e;
    logic [EW-1:0] pix_row;
    logic [EW-1:0] pix_col;
    logic [DW-1:0] k_max_idx;

    assign n_e       = EW'(cfg_n);
    assign k_e       = EW'(cfg_k);
    assign s_e       = EW'(cfg_s);
    assign k_max_idx = cfg_k - DW'(1);

    assign tap_last = (kr == k_max_idx) && (kc == k_max_idx);
    // Last window when stepping the origin would push it past the image edge.
    assign win_last = ((row + s_e + k_e) > n_e) && ((col + s_e + k_e) > n_e);

    assign pix_row   = row + EW'(kr);
    assign pix_col   = col + EW'(kc);
    assign img_addr  = AW'(pix_row) * AW'(n_e) + AW'(pix_col);
    assign kern_addr = KAW'(kr) * KAW'(cfg_k) + KAW'(kc);

    always_ff @(posedge clk) begin
        if (rst || win_init) begin
            row <= '0;
            col <= '0;
            kr  <= '0;
            kc  <= '0;
        end else begin
            if (tap_step) begin
                if (kc == k_max_idx) begin
                    kc <= '0;
                    kr <= (kr == k_max_idx) ? '0 : kr + DW'(1);
                end else begin
                    kc <= kc + DW'(1);
                end
            end
            if (win_step) begin
                if ((col + s_e + k_e) > n_e) begin
                    col <= '0;
                    row <= row + s_e;
                end else begin
                    col <= col + s_e;
                end
            end
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Image/kernel buffers, job FSM, single-MAC accumulator and valid/ready result port.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int IMG_MAX = 8,
    parameter  int K_MAX   = 5,
    localparam int AW      = conv_clog2(IMG_MAX * IMG_MAX),
    localparam int DW      = conv_clog2(IMG_MAX + 1),
    localparam int KAW     = conv_clog2(K_MAX * K_MAX),
    localparam int ACC_W   = 2 * DATA_W + KAW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic              mem_sel,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DW-1:0]     cfg_n,
    input  logic [DW-1:0]     cfg_k,
    input  logic [1:0]        cfg_stride,
    input  logic              cfg_relu,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last
);
    localparam int PW = 2 * DATA_W;

    logic [2:0] state;

    logic signed [DATA_W-1:0] img_mem  [IMG_MAX*IMG_MAX];
    logic signed [DATA_W-1:0] kern_mem [K_MAX*K_MAX];

    logic [DW-1:0]  n_q;
    logic [DW-1:0]  k_q;
    logic [1:0]     s_q;
    logic           relu_q;
    logic           err_q;

    logic [AW-1:0]  img_addr;
    logic [KAW-1:0] kern_addr;
    logic           tap_last;
    logic           win_last;
    logic           win_init;
    logic           tap_step;
    logic           win_step;
    logic           acc_clear;
    logic           write_ok;
    logic           illegal;

    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] wgt;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;

    function automatic logic [ACC_W-1:0] relu_fn(input logic signed [ACC_W-1:0] v,
                                                 input logic en);
        return (en && (v < 0)) ? '0 : v;
    endfunction

    assign illegal  = cfg_illegal(int'(n_q), int'(k_q), int'(s_q), IMG_MAX, K_MAX);
    assign write_ok = mem_we && (state == ST_IDLE);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);
    assign err  = done && err_q;

    assign win_init  = (state == ST_CHECK);
    assign tap_step  = (state == ST_MAC);
    assign win_step  = (state == ST_EMIT) && out_ready && !out_last;
    assign acc_clear = (state == ST_CHECK) || win_step;

    conv_window_addr #(
        .IMG_MAX (IMG_MAX),
        .K_MAX   (K_MAX),
        .AW      (AW),
        .DW      (DW),
        .KAW     (KAW)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .cfg_n     (n_q),
        .cfg_k     (k_q),
        .cfg_s     (s_q),
        .win_init  (win_init),
        .tap_step  (tap_step),
        .win_step  (win_step),
        .img_addr  (img_addr),
        .kern_addr (kern_addr),
        .tap_last  (tap_last),
        .win_last  (win_last)
    );

    // Buffers are only writable in IDLE, so a write issued with start lands first.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            if (!mem_sel) begin
                img_mem[mem_addr] <= mem_wdata;
            end else if (int'(mem_addr) < K_MAX * K_MAX) begin
                kern_mem[mem_addr[KAW-1:0]] <= mem_wdata;
            end
        end
    end

    // Tap product, sign-extended before the add so the accumulator never overflows.
    assign pix      = img_mem[img_addr];
    assign wgt      = kern_mem[kern_addr];
    assign prod     = PW'(pix) * PW'(wgt);
    assign prod_ext = ACC_W'(prod);
    assign acc_next = acc + prod_ext;

    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && start) begin
            n_q    <= cfg_n;
            k_q    <= cfg_k;
            s_q    <= cfg_stride;
            relu_q <= cfg_relu;
        end
        if (acc_clear) begin
            acc <= '0;
        end else if (state == ST_MAC) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_q <= illegal;
                    state <= illegal ? ST_FIN : ST_MAC;
                end
                ST_MAC: begin
                    if (tap_last) begin
                        out_data  <= relu_fn(acc_next, relu_q);
                        out_valid <= 1'b1;
                        out_last  <= win_last;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= out_last ? ST_FIN : ST_MAC;
                    end
                end
                ST_FIN: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
